// File: rtl/frame_scanner.sv
// Raster-order read controller for the ping-pong pixel buffer: streams the front buffer as pixel beats.
// Swaps buffers at a frame boundary only when the renderer has signalled a new frame; otherwise repeats.
module frame_scanner #(
  parameter int COLS   = 32,
  parameter int ROWS   = 32,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      frame_ready,
  output logic                      swap_en,
  output logic                      swap_done,
  output logic [ADDR_W-1:0]         r_addr,
  input  logic [PIX_W-1:0]          rdata,
  output logic [PIX_W-1:0]          pix_data,
  output logic [$clog2(COLS)-1:0]   pix_x,
  output logic [$clog2(ROWS)-1:0]   pix_y,
  output logic                      pix_sof,
  output logic                      pix_eol,
  output logic                      pix_eof,
  output logic                      pix_valid,
  input  logic                      pix_ready
);
  localparam int N  = COLS * ROWS;
  localparam int CW = $clog2(N + 1);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [CW-1:0] N_L    = CW'(N);
  localparam logic [CW-1:0] LAST_L = CW'(N - 1);
  localparam logic [XW-1:0] XLAST  = XW'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_END, S_SWAP} state_t;

  state_t            state;
  logic              pending;
  logic              done_q;
  logic [CW-1:0]     rc;
  logic [CW-1:0]     bc;
  logic              inflight;
  logic [PIX_W-1:0]  fifo0, fifo1;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;

  logic              pop, rd_issue, wr, fifo_pop;
  logic [PIX_W-1:0]  head;
  logic [1:0]        cnt_nxt;

  // An empty FIFO passes the in-flight read data straight through so the first beat is not delayed.
  always_comb begin
    head      = (cnt == 2'd0) ? rdata : (rd_ptr ? fifo1 : fifo0);
    pix_valid = (cnt != 2'd0) | inflight;
    pop       = pix_valid & pix_ready & en;
    fifo_pop  = pop & (cnt != 2'd0);
    wr        = inflight & ~(pop & (cnt == 2'd0));
    rd_issue  = (state == S_SCAN) && (rc < N_L) &&
                (({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    cnt_nxt   = cnt + {1'b0, wr} - {1'b0, fifo_pop};
  end

  assign r_addr    = ADDR_W'(rc);
  assign swap_en   = en & (state == S_SWAP);
  assign swap_done = en & done_q;
  assign pix_data  = pix_valid ? head : '0;
  assign pix_x     = XW'(32'(bc) % COLS);
  assign pix_y     = YW'(32'(bc) / COLS);
  assign pix_sof   = pix_valid & (bc == '0);
  assign pix_eol   = pix_valid & (pix_x == XLAST);
  assign pix_eof   = pix_valid & (bc == LAST_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pending  <= 1'b0;
      done_q   <= 1'b0;
      rc       <= '0;
      bc       <= '0;
      inflight <= 1'b0;
      fifo0    <= '0;
      fifo1    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else if (en) begin
      pending  <= (pending & (state != S_SWAP)) | frame_ready;
      done_q   <= (state == S_SWAP);
      inflight <= rd_issue;
      cnt      <= cnt_nxt;
      if (rd_issue) rc <= rc + 1'b1;
      if (pop) bc <= bc + 1'b1;
      if (wr) begin
        if (wr_ptr) fifo1 <= rdata;
        else        fifo0 <= rdata;
        wr_ptr <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case (state)
        S_IDLE: if (pending | frame_ready) state <= S_SWAP;
        S_SWAP: begin
          rc    <= '0;
          bc    <= '0;
          state <= S_SCAN;
        end
        S_SCAN: if (pop && bc == LAST_L) state <= S_END;
        S_END: begin
          // A frame_ready arriving in this very cycle still wins the swap.
          rc    <= '0;
          bc    <= '0;
          state <= (pending | frame_ready) ? S_SWAP : S_SCAN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: behavioural buffer + frame-level model, randomized pix_ready, en freeze, mid-frame reset.
module tb_frame_scanner;
  localparam int COLS = 32, ROWS = 32, ADDR_W = 10, PIX_W = 12;
  localparam int N = COLS * ROWS;

  logic clk, rst_n, en, frame_ready, pix_ready;
  logic swap_en, swap_done, pix_sof, pix_eol, pix_eof, pix_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  rdata, pix_data;
  logic [4:0] pix_x;
  logic [4:0] pix_y;

  frame_scanner #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_ready(frame_ready),
    .swap_en(swap_en), .swap_done(swap_done), .r_addr(r_addr), .rdata(rdata),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  int checks = 0, failures = 0;
  int frames = 0, beats = 0, swap_cnt = 0;
  bit rand_mode = 0;

  // ping-pong buffer: synchronous read, swap on swap_en, frozen by en
  logic [PIX_W-1:0] bank [2][N];
  logic front = 1'b0;
  logic [PIX_W-1:0] snap [N];
  logic [PIX_W-1:0] cur  [N];

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial rdata = '0;

  always @(posedge clk) begin
    if (en) begin
      rdata <= bank[front][r_addr];
      if (swap_en) front <= ~front;
    end
  end

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pix_ready = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // frame-level model: which content is displayed, where each frame must start, when swaps must occur
  bit m_idle = 1, m_pend = 0, in_gap = 0, prev_ok = 0;
  int m_bc = 0, idx = 0, swap_due = -100, first_due = -100;
  logic prev_en, prev_valid, prev_ready;
  logic [PIX_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_raddr;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_idle = 1; m_pend = 0; in_gap = 0; m_bc = 0; swap_due = -100; first_due = -100; prev_ok = 0;
    end else begin
      chk("swap_en", swap_en, en && idx == swap_due);
      chk("swap_done", swap_done, en && idx == swap_due + 1);
      if (swap_en) swap_cnt++;
      if (prev_ok && !prev_en) begin
        chk("freeze_raddr", r_addr, prev_raddr);
        chk("freeze_valid", pix_valid, prev_valid);
        chk("freeze_data", pix_data, prev_data);
      end
      if (prev_ok && prev_en && prev_valid && !prev_ready) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, prev_data);
      end
      if (in_gap) begin
        if (idx == first_due) in_gap = 0;
        else chk("gap_valid", pix_valid, 0);
      end
      if (m_idle) chk("idle_valid", pix_valid, 0);
      if (!m_idle && !in_gap) begin
        if (!rand_mode) chk("no_bubble", pix_valid, 1);
        if (pix_valid) begin
          chk("pix_data", pix_data, cur[m_bc]);
          chk("pix_x", pix_x, m_bc % COLS);
          chk("pix_y", pix_y, m_bc / COLS);
          chk("pix_sof", pix_sof, m_bc == 0);
          chk("pix_eol", pix_eol, (m_bc % COLS) == COLS - 1);
          chk("pix_eof", pix_eof, m_bc == N - 1);
          if (m_bc == 31) chk("eol_beat31", pix_eol, 1);
          if (m_bc == 33) begin chk("x_beat33", pix_x, 1); chk("y_beat33", pix_y, 1); end
          if (m_bc == 1023) chk("eof_beat1023", pix_eof, 1);
        end
      end
      if (frame_ready && en) begin
        if (m_idle) begin
          cur = snap; m_idle = 0; in_gap = 1; swap_due = idx + 1; first_due = idx + 3;
        end else m_pend = 1;
      end
      if (pix_valid && pix_ready && en && !m_idle && !in_gap) begin
        beats++;
        if (m_bc == N - 1) begin
          frames++; m_bc = 0; in_gap = 1;
          if (m_pend) begin
            cur = snap; m_pend = 0; swap_due = idx + 2; first_due = idx + 4;
          end else first_due = idx + 3;
        end else m_bc++;
      end
      prev_ok = 1; prev_en = en; prev_valid = pix_valid; prev_ready = pix_ready;
      prev_data = pix_data; prev_raddr = r_addr;
      if (en) idx++;
    end
  end

  task automatic render();
    for (int i = 0; i < N; i++) begin
      snap[i] = PIX_W'($urandom);
      bank[~front][i] = snap[i];
    end
  endtask

  task automatic pulse_fr();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic wait_frames(int f);
    int g = 0;
    while (frames < f && g < 20000) begin @(posedge clk); #1; g++; end
    if (frames < f) chk("wait_frames_timeout", frames, f);
  endtask

  task automatic wait_beat(int b);
    int g = 0;
    while (!(m_bc >= b && !in_gap && !m_idle) && g < 20000) begin @(posedge clk); #1; g++; end
    if (g >= 20000) chk("wait_beat_timeout", m_bc, b);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_swap_en"}, swap_en, 0);
    chk({tag, "_swap_done"}, swap_done, 0);
    chk({tag, "_r_addr"}, r_addr, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_data"}, pix_data, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_flags"}, {pix_sof, pix_eol, pix_eof}, 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) bank[b][i] = '0;
    rst_n = 0; en = 1; frame_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_swap", swap_cnt, 0);

    // first frame: swap timing pinned by hand
    render();
    frame_ready = 1'b1;
    @(negedge clk); chk("t0_swap_en", swap_en, 0);
    @(posedge clk); #1; frame_ready = 1'b0;
    @(negedge clk); chk("t1_swap_en", swap_en, 1); chk("t1_swap_done", swap_done, 0);
    @(negedge clk); chk("t2_swap_en", swap_en, 0); chk("t2_swap_done", swap_done, 1);
    chk("t2_r_addr", r_addr, 0);
    @(negedge clk); chk("t3_valid", pix_valid, 1); chk("t3_sof", pix_sof, 1);
    chk("t3_data", pix_data, snap[0]);

    // repeat frame without frame_ready
    wait_frames(2);
    chk("swaps_after_repeat", swap_cnt, 1);
    chk("beats_2_frames", beats, 2 * N);

    // randomized ready, new frame announced twice mid-frame
    rand_mode = 1;
    wait_beat(500);
    render();
    pulse_fr();
    wait_beat(700);
    pulse_fr();
    wait_frames(5);
    rand_mode = 0;
    chk("swaps_after_pending", swap_cnt, 2);

    // en freeze mid-scan at full throughput
    wait_beat(200);
    en = 0;
    repeat (5) begin @(posedge clk); #1; end
    en = 1;
    wait_frames(6);

    // reset mid-frame
    wait_beat(300);
    rst_n = 0;
    #1;
    chk_zero_outputs("midreset");
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1;
    repeat (20) begin @(posedge clk); #1; end
    chk("post_reset_idle", pix_valid, 0);
    render();
    pulse_fr();
    wait_frames(7);
    chk("swaps_final", swap_cnt, 3);
    chk("frames_final", frames, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
